// File: rtl/hall_sensor_conditioner.sv
// Purpose : synchronise, debounce and time an active-low Hall sensor pin.
// Latency : raw step -> hall_sensor_clean after SYNC_STAGES+DEBOUNCE_CYCLES edges;
//           strobes, event_count and period outputs move in that same cycle.
// Backpressure: none; free-running sampled input, outputs are levels/strobes.
//
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   hall_sensor_raw      asynchronous pin, 0 = magnet present
//   count_clear          synchronous clear of event counter and period state
//   hall_sensor_clean    debounced level, same polarity as the raw pin
//   magnet_present       inverse of hall_sensor_clean
//   detect_pulse         one-cycle strobe on committed 1->0 of the clean level
//   release_pulse        one-cycle strobe on committed 0->1 of the clean level
//   event_count          detect_pulse count, wraps modulo 2^COUNT_WIDTH
//   period_cycles        cycles between the last two counted detects (saturating)
//   period_update        one-cycle strobe when period_cycles loads
//   period_valid         a period has been measured since reset/clear
module hall_sensor_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int COUNT_WIDTH     = 16,
    parameter int PERIOD_WIDTH    = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hall_sensor_raw,
    input  logic                    count_clear,
    output logic                    hall_sensor_clean,
    output logic                    magnet_present,
    output logic                    detect_pulse,
    output logic                    release_pulse,
    output logic [COUNT_WIDTH-1:0]  event_count,
    output logic [PERIOD_WIDTH-1:0] period_cycles,
    output logic                    period_update,
    output logic                    period_valid
);

    localparam int QW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [QW-1:0] QUAL_ONE  = {{(QW-1){1'b0}}, 1'b1};
    localparam logic [QW-1:0] QUAL_LAST = QW'(DEBOUNCE_CYCLES - 1);

    localparam logic [COUNT_WIDTH-1:0]  COUNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PERIOD_WIDTH-1:0] PERIOD_ONE = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PERIOD_WIDTH-1:0] PERIOD_MAX = {PERIOD_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        STABLE_HIGH = 2'd0,
        QUAL_LOW    = 2'd1,
        STABLE_LOW  = 2'd2,
        QUAL_HIGH   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser. Resets to 1 (no magnet) so a pin held low through
    // reset is seen as a fresh falling step once reset releases.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], hall_sensor_raw};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debounce FSM. qual_q counts consecutive samples of the opposite
    // level; the commit happens on the sample that makes DEBOUNCE_CYCLES.
    // The clean level and strobes are registered from the committed state,
    // which adds the one edge that makes total latency SYNC+DEBOUNCE.
    // ------------------------------------------------------------------
    state_t        state_q;
    logic [QW-1:0] qual_q;
    logic          clean_q;
    logic          detect_q;
    logic          release_q;

    logic level_d;
    logic detect_d;
    logic release_d;

    // Committed level: qualifying states still present the old level.
    assign level_d   = (state_q == STABLE_HIGH) || (state_q == QUAL_LOW);
    assign detect_d  = clean_q & ~level_d;
    assign release_d = ~clean_q & level_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= STABLE_HIGH;
            qual_q    <= '0;
            clean_q   <= 1'b1;
            detect_q  <= 1'b0;
            release_q <= 1'b0;
        end else begin
            clean_q   <= level_d;
            detect_q  <= detect_d;
            release_q <= release_d;

            case (state_q)
                STABLE_HIGH: begin
                    if (!sync) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_q <= STABLE_LOW;
                        end else begin
                            state_q <= QUAL_LOW;
                            qual_q  <= QUAL_ONE;
                        end
                    end
                end
                QUAL_LOW: begin
                    if (sync) begin
                        // Glitch: abandon without touching the output.
                        state_q <= STABLE_HIGH;
                        qual_q  <= '0;
                    end else if (qual_q == QUAL_LAST) begin
                        state_q <= STABLE_LOW;
                        qual_q  <= '0;
                    end else begin
                        qual_q <= qual_q + QUAL_ONE;
                    end
                end
                STABLE_LOW: begin
                    if (sync) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_q <= STABLE_HIGH;
                        end else begin
                            state_q <= QUAL_HIGH;
                            qual_q  <= QUAL_ONE;
                        end
                    end
                end
                QUAL_HIGH: begin
                    if (!sync) begin
                        state_q <= STABLE_LOW;
                        qual_q  <= '0;
                    end else if (qual_q == QUAL_LAST) begin
                        state_q <= STABLE_HIGH;
                        qual_q  <= '0;
                    end else begin
                        qual_q <= qual_q + QUAL_ONE;
                    end
                end
                default: begin
                    state_q <= STABLE_HIGH;
                    qual_q  <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Event counter and period timer. Driven from detect_d so the count
    // and period_update land in the same cycle detect_pulse is visible.
    // The timer holds "cycles since last detect minus one", hence +1 on
    // load; it saturates so a stalled wheel reads as the maximum period.
    // ------------------------------------------------------------------
    logic [COUNT_WIDTH-1:0]  count_q;
    logic [PERIOD_WIDTH-1:0] timer_q;
    logic [PERIOD_WIDTH-1:0] period_q;
    logic                    armed_q;
    logic                    period_upd_q;
    logic                    period_vld_q;

    logic                    timer_sat;
    logic [PERIOD_WIDTH-1:0] period_d;

    assign timer_sat = (timer_q == PERIOD_MAX);
    assign period_d  = timer_sat ? PERIOD_MAX : (timer_q + PERIOD_ONE);

    always_ff @(posedge clk) begin
        if (rst || count_clear) begin
            // A detect coinciding with count_clear is deliberately dropped.
            count_q      <= '0;
            timer_q      <= '0;
            period_q     <= '0;
            armed_q      <= 1'b0;
            period_upd_q <= 1'b0;
            period_vld_q <= 1'b0;
        end else begin
            period_upd_q <= 1'b0;
            if (armed_q && !timer_sat) begin
                timer_q <= timer_q + PERIOD_ONE;
            end
            if (detect_d) begin
                count_q <= count_q + COUNT_ONE;
                timer_q <= '0;
                if (armed_q) begin
                    period_q     <= period_d;
                    period_upd_q <= 1'b1;
                    period_vld_q <= 1'b1;
                end else begin
                    // First detect after reset/clear only starts timing.
                    armed_q <= 1'b1;
                end
            end
        end
    end

    assign hall_sensor_clean = clean_q;
    assign magnet_present    = ~clean_q;
    assign detect_pulse      = detect_q;
    assign release_pulse     = release_q;
    assign event_count       = count_q;
    assign period_cycles     = period_q;
    assign period_update     = period_upd_q;
    assign period_valid      = period_vld_q;

endmodule

// File: tb/tb_hall_sensor_conditioner.sv
// Purpose : self-checking bench for hall_sensor_conditioner (SYNC=2, DEBOUNCE=4).
// Latency : expected strobes are scheduled 6 edges after the first sampling edge.
// Backpressure: none; a scoreboard queue holds expected strobes in time order.
module tb_hall_sensor_conditioner;

    logic clk = 1'b0;
    logic rst;
    logic raw;
    logic clr;

    // Main instance: full-width counter and timer.
    logic        clean_a, mp_a, det_a, rel_a, pupd_a, pvld_a;
    logic [15:0] cnt_a;
    logic [23:0] per_a;

    // Narrow instance on the same stimulus: counter wrap and period saturation.
    logic        clean_b, mp_b, det_b, rel_b, pupd_b, pvld_b;
    logic [3:0]  cnt_b;
    logic [7:0]  per_b;

    hall_sensor_conditioner #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .COUNT_WIDTH(16), .PERIOD_WIDTH(24)
    ) dut_a (
        .clk(clk), .rst(rst), .hall_sensor_raw(raw), .count_clear(clr),
        .hall_sensor_clean(clean_a), .magnet_present(mp_a),
        .detect_pulse(det_a), .release_pulse(rel_a),
        .event_count(cnt_a), .period_cycles(per_a),
        .period_update(pupd_a), .period_valid(pvld_a)
    );

    hall_sensor_conditioner #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .COUNT_WIDTH(4), .PERIOD_WIDTH(8)
    ) dut_b (
        .clk(clk), .rst(rst), .hall_sensor_raw(raw), .count_clear(clr),
        .hall_sensor_clean(clean_b), .magnet_present(mp_b),
        .detect_pulse(det_b), .release_pulse(rel_b),
        .event_count(cnt_b), .period_cycles(per_b),
        .period_update(pupd_b), .period_valid(pvld_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;   // 0 = detect, 1 = release
        int cyc;    // cycle count at the negedge where the strobe is visible
        int cnt;
        bit pupd;
        int per;
        bit valid;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    int cyc   = 0;
    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    int m_cnt;
    int m_last;
    int m_per;
    bit m_armed;
    bit m_valid;

    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Monitor: pops one expectation per observed strobe.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        n_cmp++;
        if (mp_a !== ~clean_a || mp_b !== ~clean_b) begin
            n_err++;
            $display("FAIL mp_inverse cyc=%0d clean=%b mp=%b", cyc, clean_a, mp_a);
        end
        if (det_b !== det_a || rel_b !== rel_a || clean_b !== clean_a) begin
            n_cmp++;
            n_err++;
            $display("FAIL inst_b_level cyc=%0d det=%b/%b rel=%b/%b", cyc, det_b, det_a, rel_b, rel_a);
        end
        if (sbq.size() > 0 && cyc > sbq[0].cyc) begin
            n_cmp++;
            n_err++;
            $display("FAIL missed_strobe kind=%0d got none, required at cycle %0d (now %0d)",
                     sbq[0].kind, sbq[0].cyc, cyc);
            void'(sbq.pop_front());
        end
        if (det_a || rel_a) begin
            n_cmp++;
            if (sbq.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_strobe cyc=%0d det=%b rel=%b", cyc, det_a, rel_a);
            end else begin
                mon_e = sbq.pop_front();
                if (det_a !== (mon_e.kind == 0) || rel_a !== (mon_e.kind == 1) || cyc != mon_e.cyc) begin
                    n_err++;
                    $display("FAIL strobe_timing det=%b rel=%b cyc=%0d, required kind=%0d cyc=%0d",
                             det_a, rel_a, cyc, mon_e.kind, mon_e.cyc);
                end
                n_cmp++;
                if (clean_a !== (mon_e.kind == 1)) begin
                    n_err++;
                    $display("FAIL clean_level got %b required %b", clean_a, mon_e.kind == 1);
                end
                if (mon_e.kind == 0) begin
                    n_cmp++;
                    if (cnt_a !== 16'(mon_e.cnt) || cnt_b !== 4'(mon_e.cnt)) begin
                        n_err++;
                        $display("FAIL event_count got %0d/%0d required %0d/%0d",
                                 cnt_a, cnt_b, 16'(mon_e.cnt), 4'(mon_e.cnt));
                    end
                    n_cmp++;
                    if (pupd_a !== mon_e.pupd || pupd_b !== mon_e.pupd) begin
                        n_err++;
                        $display("FAIL period_update got %b/%b required %b", pupd_a, pupd_b, mon_e.pupd);
                    end
                    n_cmp++;
                    if (pvld_a !== mon_e.valid || pvld_b !== mon_e.valid) begin
                        n_err++;
                        $display("FAIL period_valid got %b/%b required %b", pvld_a, pvld_b, mon_e.valid);
                    end
                    if (mon_e.pupd) begin
                        n_cmp++;
                        if (per_a !== 24'(mon_e.per) ||
                            per_b !== 8'((mon_e.per > 255) ? 255 : mon_e.per)) begin
                            n_err++;
                            $display("FAIL period_cycles got %0d/%0d required %0d (narrow sat 255)",
                                     per_a, per_b, mon_e.per);
                        end
                    end
                end
            end
        end else if (pupd_a || pupd_b) begin
            n_cmp++;
            n_err++;
            $display("FAIL stray_period_update cyc=%0d", cyc);
        end
    end

    // ------------------------------------------------------------------
    // One magnet pass: raw low for 'low' cycles then high for 'high'.
    // clr_off 6: count_clear sampled on the detect edge (detect dropped).
    // clr_off 7: count_clear sampled while detect_pulse is showing.
    // ------------------------------------------------------------------
    task automatic pulse(input int low, input int high, input int clr_off);
        int   n;
        exp_t e;
        @(negedge clk);
        raw = 1'b0;
        n   = cyc + 1;
        e.kind = 0;
        e.cyc  = n + 6;
        e.per  = 0;
        if (clr_off == 6) begin
            m_cnt   = 0;
            m_armed = 0;
            m_valid = 0;
            e.pupd  = 0;
        end else begin
            m_cnt++;
            if (m_armed) begin
                m_per   = e.cyc - m_last;
                m_valid = 1;
                e.pupd  = 1;
                e.per   = m_per;
            end else begin
                e.pupd  = 0;
                m_armed = 1;
            end
            m_last = e.cyc;
        end
        e.cnt   = m_cnt;
        e.valid = m_valid;
        sbq.push_back(e);
        for (int i = 1; i < low + high; i++) begin
            @(negedge clk);
            if (i == low) begin
                raw    = 1'b1;
                e.kind = 1;
                e.cyc  = cyc + 1 + 6;
                sbq.push_back(e);
            end
            if (clr_off >= 0 && i == clr_off) clr = 1'b1;
            if (clr_off >= 0 && i == clr_off + 1) begin
                clr = 1'b0;
                if (clr_off == 7) begin
                    m_cnt   = 0;
                    m_armed = 0;
                    m_valid = 0;
                end
            end
        end
    endtask

    task automatic model_reset();
        m_cnt   = 0;
        m_last  = 0;
        m_per   = 0;
        m_armed = 0;
        m_valid = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        raw = 1'b1;
        clr = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (clean_a !== 1'b1 || mp_a !== 1'b0 || det_a !== 1'b0 || rel_a !== 1'b0) begin
            n_err++;
            $display("FAIL reset_levels clean=%b mp=%b det=%b rel=%b, required 1 0 0 0",
                     clean_a, mp_a, det_a, rel_a);
        end
        n_cmp++;
        if (cnt_a !== 16'd0 || pvld_a !== 1'b0 || per_a !== 24'd0 || pupd_a !== 1'b0) begin
            n_err++;
            $display("FAIL reset_counters cnt=%0d vld=%b per=%0d upd=%b, required 0 0 0 0",
                     cnt_a, pvld_a, per_a, pupd_a);
        end
        n_cmp++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL leftover_expect got %0d pending, required 0", sbq.size());
        end
        sbq.delete();
        model_reset();
        rst = 1'b0;
    endtask

    task automatic test_basic();
        test_reset();
        pulse(20, 20, -1);
        n_cmp++;
        if (cnt_a !== 16'd1 || clean_a !== 1'b1) begin
            n_err++;
            $display("FAIL basic_final cnt=%0d clean=%b, required 1 1", cnt_a, clean_a);
        end
    endtask

    task automatic test_glitch();
        test_reset();
        @(negedge clk);
        raw = 1'b0;
        repeat (3) @(negedge clk);
        raw = 1'b1;
        repeat (10) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            raw = (k % 2 == 1);
            @(negedge clk);
        end
        pulse(20, 20, -1);
        n_cmp++;
        if (cnt_a !== 16'(m_cnt) || m_cnt != 1) begin
            n_err++;
            $display("FAIL glitch_count got %0d required 1", cnt_a);
        end
    endtask

    task automatic test_period();
        test_reset();
        pulse(20, 80, -1);
        pulse(20, 37, -1);
        pulse(20, 20, -1);
        n_cmp++;
        if (per_a !== 24'(m_per) || m_per != 57 || pvld_a !== 1'b1) begin
            n_err++;
            $display("FAIL period_final per=%0d vld=%b, required 57 1", per_a, pvld_a);
        end
    endtask

    task automatic test_clear();
        test_reset();
        pulse(20, 20, -1);
        pulse(20, 20, -1);
        pulse(20, 20, 7);
        n_cmp++;
        if (cnt_a !== 16'd0 || pvld_a !== 1'b0 || per_a !== 24'd0) begin
            n_err++;
            $display("FAIL clear_state cnt=%0d vld=%b per=%0d, required 0 0 0", cnt_a, pvld_a, per_a);
        end
        pulse(20, 20, -1);
        pulse(20, 20, 6);
        pulse(20, 280, -1);
        pulse(20, 20, -1);
        n_cmp++;
        if (per_b !== 8'd255 || per_a !== 24'd300 || cnt_a !== 16'(m_cnt)) begin
            n_err++;
            $display("FAIL saturate per_b=%0d per_a=%0d cnt=%0d, required 255 300 %0d",
                     per_b, per_a, cnt_a, m_cnt);
        end
    endtask

    task automatic test_wrap();
        test_reset();
        for (int k = 0; k < 17; k++) pulse(10, 10, -1);
        n_cmp++;
        if (cnt_b !== 4'd1 || cnt_a !== 16'd17) begin
            n_err++;
            $display("FAIL wrap_count got %0d/%0d required 1/17", cnt_b, cnt_a);
        end
    endtask

    task automatic test_reset_midqual();
        exp_t e;
        test_reset();
        @(negedge clk);
        raw = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (clean_a !== 1'b1 || det_a !== 1'b0) begin
            n_err++;
            $display("FAIL midqual_in_reset clean=%b det=%b, required 1 0", clean_a, det_a);
        end
        model_reset();
        rst = 1'b0;
        e.kind  = 0;
        e.cyc   = cyc + 1 + 6;
        e.cnt   = 1;
        e.pupd  = 0;
        e.per   = 0;
        e.valid = 0;
        sbq.push_back(e);
        repeat (12) @(negedge clk);
        raw    = 1'b1;
        e.kind = 1;
        e.cyc  = cyc + 1 + 6;
        sbq.push_back(e);
        repeat (12) @(negedge clk);
        n_cmp++;
        if (cnt_a !== 16'd1) begin
            n_err++;
            $display("FAIL midqual_count got %0d required 1", cnt_a);
        end
    endtask

    initial begin
        rst = 1'b1;
        raw = 1'b1;
        clr = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_glitch();
        test_period();
        test_clear();
        test_wrap();
        test_reset_midqual();
        repeat (20) @(negedge clk);
        n_cmp++;
        if (sbq.size() != 0) begin
            n_err++;
            $display("FAIL final_drain got %0d pending, required 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
